// File: rtl/sisc_arb_pkg.sv
// Shared encodings for the SISC memory arbiter: FSM states, owner ids, latency counter width.
package sisc_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int unsigned CNT_W = 3;

    function automatic logic [CNT_W-1:0] lat_to_cnt(input int unsigned lat);
        return lat[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sisc_arb_pick.sv
// Combinational winner select between CPU and DMA requests.
// SISC_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins ties.
module sisc_arb_pick
    import sisc_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
`ifdef SISC_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic grant,
    output logic winner
);

    always_comb begin
        grant  = cpu_req | dma_req;
        winner = OWN_CPU;
        if (!cpu_req) begin
            winner = OWN_DMA;
`ifdef SISC_ARB_RR_EN
        end else if (dma_req && (last_owner == OWN_CPU)) begin
            winner = OWN_DMA;
`endif
        end
    end

endmodule

// File: rtl/sisc_mem_arb.sv
// Multicycle arbiter sharing the single-ported SISC memory between the CPU and the DMA loader.
// Define SISC_ARB_RR_EN for round-robin tie breaking instead of fixed CPU priority.
module sisc_mem_arb
    import sisc_arb_pkg::*;
#(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_f,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner
);

    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic             grant;
    logic             winner;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

`ifdef SISC_ARB_RR_EN
    logic             last_owner;
`endif

    sisc_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
`ifdef SISC_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .grant      (grant),
        .winner     (winner)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == OWN_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    // Every output is a register; acks are asserted on entry to S_DONE so they track the state.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            busy       <= 1'b0;
            owner      <= OWN_CPU;
`ifdef SISC_ARB_RR_EN
            last_owner <= OWN_DMA;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        we_q       <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        owner      <= winner;
`ifdef SISC_ARB_RR_EN
                        last_owner <= winner;
`endif
                        mem_en     <= 1'b1;
                        mem_we     <= sel_we;
                        busy       <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (we_q) begin
                        cpu_ack <= (owner == OWN_CPU);
                        dma_ack <= (owner == OWN_DMA);
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= lat_to_cnt(MEM_LAT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            dma_rdata <= mem_rdata;
                        end
                        cpu_ack <= (owner == OWN_CPU);
                        dma_ack <= (owner == OWN_DMA);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sisc_mem_arb.md
Name: sisc_mem_arb

Overview:
Multicycle arbiter sharing the single-ported SISC memory between two requesters. Requester 0 is the CPU datapath: its fetch and LOD/STR accesses are sequenced by the control FSM. Requester 1 is the DMA/program loader. The block accepts one request at a time, latches its command, issues it to memory, waits the memory latency and returns a one-cycle acknowledge with read data to the winner.

Parameters:
AW, 16, address width
DW, 32, data width
MEM_LAT, 1, cycles from mem_en high until mem_rdata valid; legal range 1..4

Ports:
clk  in  1  system clock, posedge
rst_f  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DW  CPU read data; valid with cpu_ack, held afterwards
dma_req  in  1  DMA request; held until dma_ack
dma_we  in  1  DMA write/read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_ack  out  1  one-cycle completion pulse to DMA
dma_rdata  out  DW  DMA read data; valid with dma_ack, held afterwards
mem_en  out  1  memory strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address (latched)
mem_wdata  out  DW  memory write data (latched)
mem_rdata  in  DW  memory read data
busy  out  1  high in every state except IDLE
owner  out  1  0 = CPU, 1 = DMA; meaningful only while busy

Behaviour:
- Reset (rst_f low, asynchronous): state IDLE; all outputs 0; latched cmd regs, rdata regs and latency counter cleared; last_owner = DMA. Any in-flight access is abandoned with no ack. A write already strobed is not undone.
- States and transitions:
  - IDLE: if any req, pick winner, latch we/addr/wdata, set owner -> ISSUE; else stay.
  - ISSUE: mem_en=1, mem_we=latched we. Write -> DONE. Read -> load counter = MEM_LAT, go to WAIT.
  - WAIT: decrement counter each cycle. On the cycle the counter is 1, capture mem_rdata into the owner's rdata reg -> DONE.
  - DONE: owner's ack=1 (Moore output) -> IDLE.
- Latency from req seen in IDLE (cycle 0):
  - write: mem_en in c1, ack in c2.
  - read: mem_en in c1, ack in c(2+MEM_LAT).
- Handshake: the requester holds req and its fields stable until it samples ack. It drops req on the edge ending the ack cycle.
  - Field changes after the IDLE grant are ignored; mem_addr/mem_wdata drive from the latched regs.
  - req high in IDLE right after DONE is a new request.
- Arbitration: fixed priority, CPU wins ties. The loser stays pending and is granted at the next IDLE.
- rdata regs update only on a read by that owner. Writes leave both rdata regs unchanged.
- mem_we=0 whenever mem_en=0. Outputs not listed for a state are 0.
- Out-of-range MEM_LAT is not supported. Counter width is 3 bits.

Optional Feature:
SISC_ARB_RR_EN
- Defined: round-robin on ties. The requester not equal to last_owner wins. last_owner updates on each grant; reset value DMA makes CPU win the first tie.
- Undefined: fixed CPU priority as above; last_owner is not implemented.

Decomposition:
- Package sisc_arb_pkg:
  - state encoding constants S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_DONE=3
  - owner encoding OWN_CPU=0, OWN_DMA=1
- Sub-module sisc_arb_pick: combinational winner select from cpu_req, dma_req and last_owner; contains the SISC_ARB_RR_EN variant.

Test Plan:
1. MEM_LAT=1, CPU read 0x0010, memory returns 0xDEADBEEF -> mem_en/mem_addr=0x0010 in c1, cpu_ack only in c3, cpu_rdata=0xDEADBEEF and held after.
2. DMA write 0x0020<-0x12345678 -> mem_en=mem_we=1 for one cycle in c1, dma_ack c2, cpu_ack stays 0, both rdata unchanged.
3. Both req every cycle, 4 accesses each:
   - fixed priority: CPU granted while cpu_req pending.
   - with SISC_ARB_RR_EN: owner sequence CPU,DMA,CPU,DMA.
4. rst_f low during WAIT of a CPU read -> all outputs 0 immediately, no ack. After release, busy=0 and a new DMA read completes normally.
5. CPU changes cpu_addr 0x0040->0x0041 during ISSUE/WAIT -> mem_addr stays 0x0040.
6. MEM_LAT=3 CPU read -> mem_en c1, ack c5; rdata captured from mem_rdata valid in c4.
